// File: rtl/nf_ram_porta_arbiter_pkg.sv
// Shared definitions for the page-RAM port-A arbiter: state encoding, owner codes, default widths.
`timescale 1ns/1ps
`default_nettype none

package nf_ram_porta_arbiter_pkg;

  localparam int AW_DEFAULT = 9;
  localparam int DW_DEFAULT = 32;

  localparam logic OWN_FL  = 1'b0;
  localparam logic OWN_ECC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FL_OWN   = 2'd1,
    ST_ECC_OWN  = 2'd2,
    ST_HANDOVER = 2'd3
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/nf_rd_tag_pipe.sv
// RD_LAT-deep {valid, owner} shift register that follows each read through the RAM latency.
`timescale 1ns/1ps
`default_nettype none

module nf_rd_tag_pipe
  import nf_ram_porta_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic owner_i,
  output logic valid_o,
  output logic owner_o
);

  logic [RD_LAT-1:0] valid_q;
  logic [RD_LAT-1:0] owner_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      owner_q <= {RD_LAT{OWN_FL}};
    end else begin
      valid_q[0] <= push_i;
      owner_q[0] <= owner_i;
      for (int i = 1; i < RD_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        owner_q[i] <= owner_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[RD_LAT-1];
  assign owner_o = owner_q[RD_LAT-1];

endmodule

`default_nettype wire

// File: rtl/nf_ram_porta_arbiter.sv
// Req/gnt scheduler sharing page-RAM port A between the flash engine (R/W) and the ECC engine (R).
// Grants lock the port per burst, a burst cap forces handover, and reads are tagged back to their issuer.
`timescale 1ns/1ps
`default_nettype none

module nf_ram_porta_arbiter
  import nf_ram_porta_arbiter_pkg::*;
#(
  parameter int AW        = AW_DEFAULT,
  parameter int DW        = DW_DEFAULT,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fl_req,
  input  logic          fl_en,
  input  logic          fl_we,
  input  logic [AW-1:0] fl_addr,
  input  logic [DW-1:0] fl_wdat,
  output logic          fl_gnt,
  output logic          fl_rvalid,
  input  logic          ecc_req,
  input  logic          ecc_en,
  input  logic [AW-1:0] ecc_addr,
  output logic          ecc_gnt,
  output logic          ecc_rvalid,
  output logic [DW-1:0] rdat,
  output logic [AW-1:0] ram_addra,
  output logic [DW-1:0] ram_dina,
  output logic          ram_wea,
  input  logic [DW-1:0] ram_douta,
  output logic          protocol_err
);

  localparam int             CW    = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]  C_MAX = CW'(MAX_BURST);

  arb_state_t     state_q;
  logic           fl_gnt_q;
  logic           ecc_gnt_q;
  logic           last_owner_q;
  logic           perr_q;
  logic [CW-1:0]  burst_cnt_q;
  logic [CW-1:0]  burst_cnt_d;
  logic [AW-1:0]  addr_hold_q;

  logic w_fl_acc;
  logic w_ecc_acc;
  logic w_err;
  logic w_rd_push;
  logic w_tag_valid;
  logic w_tag_owner;

  assign w_fl_acc    = fl_en & fl_gnt_q;
  assign w_ecc_acc   = ecc_en & ecc_gnt_q;
  assign w_err       = (fl_en & ~fl_gnt_q) | (ecc_en & ~ecc_gnt_q);
  assign w_rd_push   = (w_fl_acc & ~fl_we) | w_ecc_acc;
  // Count includes this cycle's access so the port is released right after the capped access.
  assign burst_cnt_d = burst_cnt_q + CW'(w_fl_acc | w_ecc_acc);

  assign ram_addra = fl_gnt_q ? fl_addr : (ecc_gnt_q ? ecc_addr : addr_hold_q);
  assign ram_dina  = fl_wdat;
  assign ram_wea   = w_fl_acc & fl_we;
  assign rdat      = ram_douta;

  assign fl_gnt       = fl_gnt_q;
  assign ecc_gnt      = ecc_gnt_q;
  assign protocol_err = perr_q;
  assign fl_rvalid    = w_tag_valid & (w_tag_owner == OWN_FL);
  assign ecc_rvalid   = w_tag_valid & (w_tag_owner == OWN_ECC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      fl_gnt_q     <= 1'b0;
      ecc_gnt_q    <= 1'b0;
      last_owner_q <= OWN_ECC;
      burst_cnt_q  <= '0;
      perr_q       <= 1'b0;
      addr_hold_q  <= '0;
    end else begin
      perr_q      <= w_err;
      addr_hold_q <= ram_addra;
      case (state_q)
        ST_IDLE: begin
          burst_cnt_q <= '0;
          if (fl_req && (!ecc_req || last_owner_q == OWN_ECC)) begin
            state_q  <= ST_FL_OWN;
            fl_gnt_q <= 1'b1;
          end else if (ecc_req) begin
            state_q   <= ST_ECC_OWN;
            ecc_gnt_q <= 1'b1;
          end
        end
        ST_FL_OWN: begin
          if (!fl_req) begin
            state_q      <= ST_IDLE;
            fl_gnt_q     <= 1'b0;
            last_owner_q <= OWN_FL;
            burst_cnt_q  <= '0;
          end else if (burst_cnt_d == C_MAX) begin
            burst_cnt_q <= '0;
            if (ecc_req) begin
              state_q      <= ST_HANDOVER;
              fl_gnt_q     <= 1'b0;
              last_owner_q <= OWN_FL;
            end
          end else begin
            burst_cnt_q <= burst_cnt_d;
          end
        end
        ST_ECC_OWN: begin
          if (!ecc_req) begin
            state_q      <= ST_IDLE;
            ecc_gnt_q    <= 1'b0;
            last_owner_q <= OWN_ECC;
            burst_cnt_q  <= '0;
          end else if (burst_cnt_d == C_MAX) begin
            burst_cnt_q <= '0;
            if (fl_req) begin
              state_q      <= ST_HANDOVER;
              ecc_gnt_q    <= 1'b0;
              last_owner_q <= OWN_ECC;
            end
          end else begin
            burst_cnt_q <= burst_cnt_d;
          end
        end
        ST_HANDOVER: begin
          burst_cnt_q <= '0;
          if (last_owner_q == OWN_FL) begin
            if (ecc_req) begin
              state_q   <= ST_ECC_OWN;
              ecc_gnt_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            if (fl_req) begin
              state_q  <= ST_FL_OWN;
              fl_gnt_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          fl_gnt_q  <= 1'b0;
          ecc_gnt_q <= 1'b0;
        end
      endcase
    end
  end

  nf_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_rd_push),
    .owner_i (ecc_gnt_q ? OWN_ECC : OWN_FL),
    .valid_o (w_tag_valid),
    .owner_o (w_tag_owner)
  );

endmodule

`default_nettype wire

// File: tb/tb_nf_ram_porta_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level arbitration model.
`timescale 1ns/1ps
`default_nettype none

module tb_nf_ram_porta_arbiter;

  localparam int AW        = 9;
  localparam int DW        = 32;
  localparam int RD_LAT    = 2;
  localparam int MAX_BURST = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fl_req, fl_en, fl_we;
  logic [AW-1:0] fl_addr;
  logic [DW-1:0] fl_wdat;
  logic          fl_gnt, fl_rvalid;
  logic          ecc_req, ecc_en;
  logic [AW-1:0] ecc_addr;
  logic          ecc_gnt, ecc_rvalid;
  logic [DW-1:0] rdat;
  logic [AW-1:0] ram_addra;
  logic [DW-1:0] ram_dina;
  logic          ram_wea;
  logic [DW-1:0] ram_douta;
  logic          protocol_err;

  always #5 clk = ~clk;

  nf_ram_porta_arbiter #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fl_req(fl_req), .fl_en(fl_en), .fl_we(fl_we), .fl_addr(fl_addr), .fl_wdat(fl_wdat),
    .fl_gnt(fl_gnt), .fl_rvalid(fl_rvalid),
    .ecc_req(ecc_req), .ecc_en(ecc_en), .ecc_addr(ecc_addr),
    .ecc_gnt(ecc_gnt), .ecc_rvalid(ecc_rvalid),
    .rdat(rdat), .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_wea(ram_wea),
    .ram_douta(ram_douta), .protocol_err(protocol_err)
  );

  // Behavioural dual-port RAM port A with RD_LAT read latency.
  logic [DW-1:0] ram [512];
  logic [DW-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 512; i++) ram[i] <= '0;
      for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= '0;
    end else begin
      if (ram_wea) ram[ram_addra] <= ram_dina;
      rd_pipe[0] <= ram[ram_addra];
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end
  assign ram_douta = rd_pipe[RD_LAT-1];

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the port, how many accesses this grant used, pending returns.
  typedef struct { int due; bit ecc; logic [DW-1:0] data; } rd_t;
  rd_t           rq[$];
  logic [DW-1:0] mem_m [512];
  int            own;        // 0 none, 1 flash, 2 ecc
  bit            dead;       // one idle cycle owed before the preempting side gets the port
  bit            last_ecc;
  int            used;
  int            cyc;
  bit            err_pend;
  logic [AW-1:0] hold;

  int            n_wea, n_frv, n_erv, n_perr;
  logic [DW-1:0] got_e[$];
  logic [DW-1:0] got_f[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    own = 0; dead = 0; last_ecc = 1; used = 0; err_pend = 0; hold = '0;
    rq.delete();
    for (int i = 0; i < 512; i++) mem_m[i] = '0;
  endtask

  task automatic clear_stats();
    n_wea = 0; n_frv = 0; n_erv = 0; n_perr = 0;
    got_e.delete(); got_f.delete();
  endtask

  function automatic logic [AW-1:0] exp_addr();
    if (own == 1) return fl_addr;
    if (own == 2) return ecc_addr;
    return hold;
  endfunction

  task automatic check_outputs();
    bit efv, eev;
    logic [DW-1:0] ed;
    efv = 0; eev = 0; ed = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      efv = !rq[0].ecc; eev = rq[0].ecc; ed = rq[0].data;
    end
    chk("fl_gnt", fl_gnt, own == 1);
    chk("ecc_gnt", ecc_gnt, own == 2);
    chk("ram_addra", ram_addra, exp_addr());
    chk("ram_wea", ram_wea, (own == 1) && fl_en && fl_we);
    if ((own == 1) && fl_en && fl_we) chk("ram_dina", ram_dina, fl_wdat);
    chk("protocol_err", protocol_err, err_pend);
    chk("fl_rvalid", fl_rvalid, efv);
    chk("ecc_rvalid", ecc_rvalid, eev);
    if (efv || eev) begin
      chk("rdat", rdat, ed);
      void'(rq.pop_front());
    end
    n_wea += ram_wea; n_frv += fl_rvalid; n_erv += ecc_rvalid; n_perr += protocol_err;
    if (ecc_rvalid) got_e.push_back(rdat);
    if (fl_rvalid)  got_f.push_back(rdat);
  endtask

  task automatic model_update();
    bit fa, ea;
    if (!rst_n) begin
      model_reset();
    end else begin
      fa = fl_en && own == 1;
      ea = ecc_en && own == 2;
      err_pend = (fl_en && own != 1) || (ecc_en && own != 2);
      hold = exp_addr();
      if (fa && !fl_we) rq.push_back('{due: cyc + RD_LAT, ecc: 1'b0, data: mem_m[fl_addr]});
      if (ea)           rq.push_back('{due: cyc + RD_LAT, ecc: 1'b1, data: mem_m[ecc_addr]});
      if (fa && fl_we)  mem_m[fl_addr] = fl_wdat;
      if (fa || ea) used++;
      case (own)
        0: begin
          used = 0;
          if (dead) begin
            dead = 0;
            if (last_ecc ? fl_req : ecc_req) own = last_ecc ? 1 : 2;
          end else if (fl_req && ecc_req) own = last_ecc ? 1 : 2;
          else if (fl_req) own = 1;
          else if (ecc_req) own = 2;
        end
        1: begin
          if (!fl_req) begin own = 0; last_ecc = 0; used = 0; end
          else if (used == MAX_BURST) begin
            used = 0;
            if (ecc_req) begin own = 0; dead = 1; last_ecc = 0; end
          end
        end
        default: begin
          if (!ecc_req) begin own = 0; last_ecc = 1; used = 0; end
          else if (used == MAX_BURST) begin
            used = 0;
            if (fl_req) begin own = 0; dead = 1; last_ecc = 1; end
          end
        end
      endcase
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic inputs_idle();
    fl_req = 0; fl_en = 0; fl_we = 0; fl_addr = '0; fl_wdat = '0;
    ecc_req = 0; ecc_en = 0; ecc_addr = '0;
  endtask

  initial begin
    cyc = 0;
    inputs_idle();
    clear_stats();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Simultaneous requests: flash wins first, ECC wins the next tie.
    fl_req = 1; ecc_req = 1;
    tick();
    chk("tie1_fl_gnt", fl_gnt, 1);
    chk("tie1_ecc_gnt", ecc_gnt, 0);
    fl_req = 0; ecc_req = 0;
    repeat (2) tick();
    fl_req = 1; ecc_req = 1;
    tick();
    chk("tie2_ecc_gnt", ecc_gnt, 1);
    chk("tie2_fl_gnt", fl_gnt, 0);
    fl_req = 0; ecc_req = 0;
    repeat (2) tick();

    // Flash writes 0xA0..0xA3 to 0x010..0x013.
    clear_stats();
    fl_req = 1;
    tick();
    chk("t1_gnt_latency", fl_gnt, 1);
    for (int i = 0; i < 4; i++) begin
      fl_en = 1; fl_we = 1; fl_addr = AW'(9'h010 + i); fl_wdat = 32'hA0 + i;
      tick();
    end
    fl_en = 0; fl_we = 0; fl_req = 0;
    repeat (4) tick();
    chk("t1_wea_cycles", n_wea, 4);
    chk("t1_no_rvalid", n_frv + n_erv, 0);

    // ECC reads them back.
    clear_stats();
    ecc_req = 1;
    tick();
    chk("t2_ecc_gnt", ecc_gnt, 1);
    for (int i = 0; i < 4; i++) begin
      ecc_en = 1; ecc_addr = AW'(9'h010 + i);
      tick();
    end
    ecc_en = 0; ecc_req = 0;
    repeat (RD_LAT + 2) tick();
    chk("t2_ecc_rvalid_cnt", n_erv, 4);
    chk("t2_fl_rvalid_cnt", n_frv, 0);
    for (int i = 0; i < 4; i++)
      chk("t2_rdat", (i < got_e.size()) ? got_e[i] : 32'hDEADBEEF, 32'hA0 + i);

    // Burst cap: flash streams reads while ECC waits.
    clear_stats();
    fl_req = 1; ecc_req = 1;
    tick();
    chk("t4_fl_first", fl_gnt, 1);
    for (int i = 0; i < 4; i++) begin
      fl_en = 1; fl_we = 0; fl_addr = AW'(9'h010 + i);
      tick();
    end
    fl_en = 0;
    chk("t4_fl_dropped", fl_gnt, 0);
    chk("t4_dead_cycle", ecc_gnt, 0);
    tick();
    chk("t4_ecc_granted", ecc_gnt, 1);
    repeat (RD_LAT) tick();
    chk("t4_fl_rvalid_cnt", n_frv, 4);
    chk("t4_last_rdat", (got_f.size() == 4) ? got_f[3] : 32'hDEADBEEF, 32'hA3);
    ecc_req = 0;
    repeat (2) tick();
    chk("t4_fl_regranted", fl_gnt, 1);
    inputs_idle();
    repeat (3) tick();

    // Strobe from the non-owner is ignored and flagged once.
    clear_stats();
    fl_req = 1; fl_addr = 9'h055;
    tick();
    ecc_en = 1; ecc_addr = 9'h1AA;
    #1;
    chk("t5_addr_kept", ram_addra, 9'h055);
    tick();
    ecc_en = 0;
    repeat (RD_LAT + 2) tick();
    chk("t5_perr_pulses", n_perr, 1);
    chk("t5_no_ecc_rvalid", n_erv, 0);
    inputs_idle();
    repeat (2) tick();

    // Random traffic.
    repeat (3000) begin
      if ($urandom_range(0, 9) == 0) fl_req = ~fl_req;
      if ($urandom_range(0, 9) == 0) ecc_req = ~ecc_req;
      fl_en    = (own == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 31) == 0);
      fl_we    = 1'($urandom_range(0, 1));
      fl_addr  = AW'($urandom_range(0, 15));
      fl_wdat  = $urandom;
      ecc_en   = (own == 2) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 31) == 0);
      ecc_addr = AW'($urandom_range(0, 15));
      tick();
    end

    // Reset with a read in flight.
    inputs_idle();
    repeat (3) tick();
    fl_req = 1;
    tick();
    fl_en = 1; fl_we = 0; fl_addr = 9'h003;
    tick();
    fl_en = 0;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_fl_gnt", fl_gnt, 0);
    chk("t6_ecc_gnt", ecc_gnt, 0);
    chk("t6_fl_rvalid", fl_rvalid, 0);
    chk("t6_ecc_rvalid", ecc_rvalid, 0);
    chk("t6_wea", ram_wea, 0);
    chk("t6_perr", protocol_err, 0);
    chk("t6_addr", ram_addra, 0);
    inputs_idle();
    clear_stats();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("t6_no_rvalid_after", n_frv + n_erv, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
